// File: rtl/mcu_bridge_pkg.sv
// Shared constants for the AHB-to-APB bridge: FSM encoding, HTRANS codes and PPROT bit positions.
// Also provides the HPROT to PPROT mapping used when a transfer is accepted.
package mcu_bridge_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR1   = 3'd5;
    localparam logic [2:0] ST_ERR2   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_SETUP  = ST_SETUP,
        S_ACCESS = ST_ACCESS,
        S_DONE   = ST_DONE,
        S_ERR1   = ST_ERR1,
        S_ERR2   = ST_ERR2
    } bridge_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int PPROT_PRIV_BIT   = 0;
    localparam int PPROT_NSEC_BIT   = 1;
    localparam int PPROT_INSTR_BIT  = 2;

    localparam int HPROT_DATA_BIT   = 0;
    localparam int HPROT_PRIV_BIT   = 1;

    // AHB marks data accesses with HPROT[0]=1; APB marks instruction fetches with PPROT[2]=1.
    function automatic logic [2:0] map_pprot(input logic [3:0] hprot);
        logic [2:0] p;
        p                  = '0;
        p[PPROT_PRIV_BIT]  = hprot[HPROT_PRIV_BIT];
        p[PPROT_NSEC_BIT]  = 1'b0;
        p[PPROT_INSTR_BIT] = ~hprot[HPROT_DATA_BIT];
        return p;
    endfunction

endpackage

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB master bridge, same clock; 4-cycle minimum transfer latency (+1 per APB wait state).
// Backpressure: HREADYOUT is held low from the data phase until the APB access completes; PREADY stretches ACCESS.
module ahb_to_apb_bridge (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [15:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [15:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [2:0]  PPROT,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);
    import mcu_bridge_pkg::*;

    bridge_state_e state_q, state_d;

    logic        psel_q,      psel_d;
    logic        penable_q,   penable_d;
    logic        pwrite_q,    pwrite_d;
    logic [15:0] paddr_q,     paddr_d;
    logic [31:0] pwdata_q,    pwdata_d;
    logic [2:0]  pprot_q,     pprot_d;
    logic [31:0] hrdata_q,    hrdata_d;
    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q,     hresp_d;

    logic accept;
    logic apb_done;
    logic unused_inputs;

    // Transfers are 32-bit only, so size and the low address bits carry no information here.
    assign unused_inputs = ^{HSIZE, HADDR[1:0], HTRANS[0], HPROT[3:2]};

    assign accept   = HSEL & HTRANS[1] & HREADY;
    assign apb_done = psel_q & penable_q & PREADY;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pprot_d  = pprot_q;
        pwdata_d = pwdata_q;
        hrdata_d = '0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR2: begin
                if (accept) begin
                    state_d  = S_WAIT;
                    paddr_d  = {HADDR[15:2], 2'b00};
                    pwrite_d = HWRITE;
                    pprot_d  = map_pprot(HPROT);
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_WAIT: begin
                state_d = S_SETUP;
                // Reads leave the last written data on PWDATA rather than sampling an undriven HWDATA.
                if (pwrite_q) begin
                    pwdata_d = HWDATA;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (apb_done) begin
                    if (PSLVERR) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d = S_DONE;
                        if (!pwrite_q) begin
                            hrdata_d = PRDATA;
                        end
                    end
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // All bus-facing controls are registered decodes of the next state.
        psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d   = (state_d == S_ACCESS);
        hreadyout_d = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR2);
        hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pprot_q     <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pprot_q     <= pprot_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PPROT     = pprot_q;
    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule
